clock_mode_ctrl: RTL and testbench

Timekeeping controller for the digital clock. It owns the hours/minutes/seconds counters and the 1 Hz prescaler. It sequences the run and set modes from two active-low push buttons, and produces the ms/mm/mh mode flags consumed by the display and blink logic. It replaces the standalone mode FSM plus free-running counters with one block that both schedules counting and gates the set operations.

---
 rtl/clock_mode_ctrl.sv | 127 ++++++++++++
 tb/tb_clock_mode_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/clock_mode_ctrl.sv
// Timekeeping controller: owns the H:M:S counters and the 1 Hz prescaler,
// sequences RUN/SET modes from two active-low buttons, and decodes the mode flags.
module clock_mode_ctrl #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       nextP,
  input  logic       incP,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hr,
  output logic       ms,
  output logic       mm,
  output logic       mh,
  output logic       sec_tick
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {RUN, SET_SEC, SET_MIN, SET_HR} mode_t;

  mode_t         state, state_nxt;
  logic [PW-1:0] presc;

  logic next_p0, next_p1, next_p2;
  logic inc_p0, inc_p1, inc_p2;
  logic nxt_press, inc_press;

  function automatic logic [5:0] wrap_inc6(input logic [5:0] v, input logic [5:0] lim);
    return (v == lim) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [4:0] wrap_inc5(input logic [4:0] v, input logic [4:0] lim);
    return (v == lim) ? 5'd0 : v + 5'd1;
  endfunction

  // Stage p0/p1: two-flop synchronizer; stage p2: previous synced value for edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      next_p0 <= 1'b1;
      next_p1 <= 1'b1;
      next_p2 <= 1'b1;
      inc_p0  <= 1'b1;
      inc_p1  <= 1'b1;
      inc_p2  <= 1'b1;
    end else begin
      next_p0 <= nextP;
      next_p1 <= next_p0;
      next_p2 <= next_p1;
      inc_p0  <= incP;
      inc_p1  <= inc_p0;
      inc_p2  <= inc_p1;
    end
  end

  assign nxt_press = ~next_p1 & next_p2;
  assign inc_press = ~inc_p1 & inc_p2;

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ms        = 1'b0;
    mm        = 1'b0;
    mh        = 1'b0;
    case (state)
      RUN:     if (nxt_press) state_nxt = SET_SEC;
      SET_SEC: begin
        ms = 1'b1;
        if (nxt_press) state_nxt = SET_MIN;
      end
      SET_MIN: begin
        mm = 1'b1;
        if (nxt_press) state_nxt = SET_HR;
      end
      SET_HR:  begin
        mh = 1'b1;
        if (nxt_press) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // A mode press on the tick edge cancels the tick and restarts the prescaler
  always_ff @(posedge clk) begin
    if (rst) begin
      presc    <= '0;
      sec_tick <= 1'b0;
      sec      <= 6'd0;
      min      <= 6'd0;
      hr       <= 5'd0;
    end else begin
      sec_tick <= 1'b0;
      if (state == RUN) begin
        if (nxt_press) begin
          presc <= '0;
        end else if (presc == PMAX) begin
          presc    <= '0;
          sec_tick <= 1'b1;
          sec      <= wrap_inc6(sec, 6'd59);
          if (sec == 6'd59) begin
            min <= wrap_inc6(min, 6'd59);
            if (min == 6'd59) hr <= wrap_inc5(hr, 5'd23);
          end
        end else begin
          presc <= presc + PW'(1);
        end
      end else begin
        presc <= '0;
        if (inc_press && !nxt_press) begin
          case (state)
            SET_SEC: sec <= wrap_inc6(sec, 6'd59);
            SET_MIN: min <= wrap_inc6(min, 6'd59);
            SET_HR:  hr  <= wrap_inc5(hr, 5'd23);
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl with TICK_DIV=4; inputs driven 1 time unit
// after each rising edge, outputs sampled at the same point.
module tb_clock_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       nextP = 1'b1;
  logic       incP = 1'b1;
  logic [5:0] sec, min;
  logic [4:0] hr;
  logic       ms, mm, mh, sec_tick;

  int n_checks = 0;
  int n_errors = 0;

  clock_mode_ctrl #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .nextP(nextP), .incP(incP),
    .sec(sec), .min(min), .hr(hr),
    .ms(ms), .mm(mm), .mh(mh), .sec_tick(sec_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int flags();
    return int'({ms, mm, mh});
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic nlev, input logic ilev);
    rst = 1'b1; nextP = nlev; incP = ilev;
    step(2);
    rst = 1'b0;
  endtask

  // One-cycle low pulse; returns right after the edge that applies the update (E0+2)
  task automatic press(input logic n, input logic i);
    nextP = ~n; incP = ~i;
    step(1);
    nextP = 1'b1; incP = 1'b1;
    step(2);
  endtask

  task automatic press_inc(input int k);
    repeat (k) press(1'b0, 1'b1);
  endtask

  int first, cnt;
  int expf [4] = '{4, 2, 1, 0};
  int prevf;

  initial begin
    // reset values after the first reset edge
    step(1);
    check("rst_sec", sec, 0); check("rst_min", min, 0); check("rst_hr", hr, 0);
    check("rst_flags", flags(), 0); check("rst_tick", sec_tick, 0);
    step(1);
    rst = 1'b0;

    // count to 00:00:37, then reset mid-count
    step(148);
    check("run37_sec", sec, 37); check("run37_min", min, 0);
    rst = 1'b1;
    step(2);
    check("midrst_sec", sec, 0); check("midrst_flags", flags(), 0);
    check("midrst_tick", sec_tick, 0);
    rst = 1'b0;

    // 240 cycles of run counting
    first = -1; cnt = 0;
    for (int c = 1; c <= 240; c++) begin
      step(1);
      if (sec_tick) begin
        cnt++;
        if (first < 0) first = c;
      end
    end
    check("first_tick", first, 4); check("tick_count", cnt, 60);
    check("run240_hr", hr, 0); check("run240_min", min, 1); check("run240_sec", sec, 0);

    // mode cycling with latency check
    prevf = 0;
    for (int i = 0; i < 4; i++) begin
      nextP = 1'b0;
      step(1);
      nextP = 1'b1;
      step(1);
      check("mode_early", flags(), prevf);
      step(1);
      check("mode_adv", flags(), expf[i]);
      prevf = expf[i];
      step(2);
    end

    // held nextP advances once
    nextP = 1'b0;
    step(20);
    check("hold_next", flags(), 4);
    nextP = 1'b1;
    step(5);
    check("hold_next_rel", flags(), 4);

    // set wrap
    do_reset(1'b1, 1'b1);
    press(1'b1, 1'b0);
    check("enter_setsec", flags(), 4); check("enter_setsec_sec", sec, 0);
    press_inc(61);
    check("setsec_sec", sec, 1); check("setsec_min", min, 0);
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      step(1);
      if (sec_tick) cnt++;
    end
    check("set_idle_ticks", cnt, 0); check("set_idle_sec", sec, 1);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    check("enter_sethr", flags(), 1);
    press_inc(25);
    check("sethr_hr", hr, 1); check("sethr_min", min, 0); check("sethr_sec", sec, 1);

    // simultaneous presses in SET_SEC
    do_reset(1'b1, 1'b1);
    press(1'b1, 1'b0);
    press_inc(5);
    press(1'b1, 1'b1);
    check("simul_flags", flags(), 2); check("simul_sec", sec, 5); check("simul_min", min, 0);

    // reset while in SET_MIN
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    check("rst_setmin_flags", flags(), 0); check("rst_setmin_sec", sec, 0);
    step(4);
    check("rst_setmin_run_sec", sec, 1); check("rst_setmin_run_tick", sec_tick, 1);

    // rollover 23:59:59 -> 00:00:00
    do_reset(1'b1, 1'b1);
    press(1'b1, 1'b0);
    press_inc(59);
    press(1'b1, 1'b0);
    press_inc(59);
    press(1'b1, 1'b0);
    press_inc(23);
    check("roll_set_hr", hr, 23); check("roll_set_min", min, 59); check("roll_set_sec", sec, 59);
    press(1'b1, 1'b0);
    check("roll_run_flags", flags(), 0);
    step(3);
    check("roll_pre_sec", sec, 59); check("roll_pre_tick", sec_tick, 0);
    step(1);
    check("roll_sec", sec, 0); check("roll_min", min, 0); check("roll_hr", hr, 0);
    check("roll_tick", sec_tick, 1);
    step(1);
    check("roll_tick_off", sec_tick, 0);

    // nextP held low through reset release: exactly one press
    do_reset(1'b0, 1'b1);
    step(2);
    check("hold_rst_next_early", flags(), 0);
    step(1);
    check("hold_rst_next", flags(), 4);
    step(10);
    check("hold_rst_next_once", flags(), 4);
    nextP = 1'b1;
    step(3);
    check("hold_rst_next_rel", flags(), 4);

    // incP held low through reset release: ignored in RUN
    do_reset(1'b1, 1'b0);
    step(3);
    check("hold_rst_inc_sec", sec, 0); check("hold_rst_inc_flags", flags(), 0);
    step(1);
    check("hold_rst_inc_tick_sec", sec, 1); check("hold_rst_inc_tick", sec_tick, 1);
    incP = 1'b1;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
